texel_quad_fetch: RTL and testbench
===================================

# texel_quad_fetch

Bilinear texel fetch unit that produces the four-texel quad and 16-bit sub-texel fractions consumed by the texture filter stage. It takes one normalized S/T coordinate per transaction and applies the texture size and wrap mode. It then issues sequential reads to a single-port texture memory and presents texel00/01/10/11 plus sub-coordinates on a valid/ready master port. It sits between the texture coordinate interpolator and the texture filter.

## Interface
- USER_WIDTH, 1: sideband passed through unchanged.
- ADDR_WIDTH, 16: texel address width.
- PIXEL_WIDTH, 32 (localparam): texel width, RGBA8888.
- aclk  in  1  clock.
- resetn  in  1  reset; one clock, asynchronous, active-low.
- enable  in  1  1 = bilinear (4 reads), 0 = nearest (1 read); latched at accept.
- conf_widthLog2, conf_heightLog2  in  4 each  texture size log2; legal range 0..8; latched at accept.
- conf_clampS, conf_clampT  in  1 each  1 = clamp-to-edge, 0 = repeat; latched at accept.
- s_ready  out  1; s_valid  in  1; s_user  in  USER_WIDTH.
- s_texelS, s_texelT  in  32 each  signed Q16.16 normalized coordinate (1.0 = 0x00010000).
- m_tex_rd  out  1  read strobe.
- m_tex_addr  out  ADDR_WIDTH  read address.
- m_tex_data  in  PIXEL_WIDTH  read data, valid exactly one cycle after m_tex_rd.
- m_ready  in  1; m_valid  out  1; m_user  out  USER_WIDTH.
- m_texel00, m_texel01, m_texel10, m_texel11  out  PIXEL_WIDTH each.
- m_texelSubCoordS, m_texelSubCoordT  out  16 each.

## Operation
- Coordinate math is 32-bit two's complement, and overflow wraps.
  - Filtered: u = (S << widthLog2) - 0x8000.
  - Nearest: u = S << widthLog2.
  - v is computed the same way from T.
- Integer parts: u0 = u[31:16] signed, u1 = u0 + 1. v0 and v1 are derived the same way.
- Sub-coordinates: SubS = u[15:0] and SubT = v[15:0] when filtered; both are 0 when nearest.
- Repeat mode: coordinate AND (size - 1).
- Clamp mode: <0 gives 0; >size-1 gives size-1. u0, u1, v0 and v1 are clamped independently.
- Address = (v << widthLog2) | u, truncated to ADDR_WIDTH.
- Quad mapping:
  - texel00 = (u0,v0)
  - texel01 = (u1,v0)
  - texel10 = (u0,v1)
  - texel11 = (u1,v1)
- In nearest mode texel01, texel10 and texel11 are copies of texel00.
- FSM states: IDLE, F0, F1, F2, F3, WAIT, OUT.
  - IDLE: on s_valid, latch inputs and config, then go to F0.
  - F0..F3: each state issues one read in the order 00, 01, 10, 11. Each read's data is captured in the following state.
  - Nearest mode goes F0 -> WAIT.
  - WAIT: captures the last datum, then goes to OUT.
  - OUT: m_valid = 1. On m_ready, go to IDLE. If s_valid is also high, go straight to F0 with the new transaction latched.
- s_ready = (state == IDLE) || (state == OUT && m_ready).
- m_tex_rd is high only in F0..F3, for exactly one cycle per read.

## Timing
- Reset values:
  - state = IDLE, s_ready = 1.
  - m_valid = 0, m_tex_rd = 0, m_tex_addr = 0.
  - All m_texel*, m_texelSubCoord* and m_user = 0.
- Reset during a fetch abandons the transaction. Data returned after reset is ignored.
- Latency, with acceptance in cycle 0:
  - Filtered: reads in cycles 1–4; m_valid asserted in cycle 6.
  - Nearest: read in cycle 1; m_valid asserted in cycle 3.
- Throughput: one quad per 6 cycles filtered, one per 3 cycles nearest, when back-to-back.
- Outputs are registered. While m_valid = 1 and m_ready = 0, all m_* outputs hold and no reads are issued.
- m_valid never deasserts without m_ready.

## Configuration
- TEXEL_QUAD_FETCH_CLAMP_EN:
  - Defined: conf_clampS and conf_clampT select clamp-to-edge per axis.
  - Undefined: the clamp comparators are removed, both clamp inputs are ignored, and repeat mode is always used.

## Test plan
All scenarios use width = height = 4 (log2 = 2) and mem[a] = a.
- Filtered centre: S = T = 0x8000, enable = 1, repeat.
  - Reads 5, 6, 9, 10.
  - texel00/01/10/11 = 5/6/9/10, SubS = SubT = 0x8000.
  - m_valid in cycle 6.
- Repeat wrap: S = T = 0, enable = 1, clamp = 0.
  - Quad = 15/12/3/0, SubS = SubT = 0x8000.
- Clamp (macro defined): S = T = 0, clampS = clampT = 1.
  - Quad = 0/0/0/0.
  - Same stimulus with the macro undefined gives 15/12/3/0.
- Nearest: enable = 0, S = 0x8000, T = 0x4000.
  - Exactly one read, at address 6.
  - All four texels = 6, SubS = SubT = 0.
  - m_valid in cycle 3.
- Backpressure: hold m_ready = 0 for 5 cycles in OUT, with s_valid = 1 and a second sample pending.
  - Outputs stable and no m_tex_rd during the stall.
  - The second sample is accepted in the same cycle m_ready rises.
- Reset mid-fetch: assert resetn = 0 during F2.
  - All outputs take reset values immediately.
  - The next transaction's quad is correct.

Source files
------------

// File: rtl/texel_quad_fetch.sv
// Bilinear / nearest texel quad fetch over a single-port texture memory.
// Define TEXEL_QUAD_FETCH_CLAMP_EN to enable per-axis clamp-to-edge addressing.
module texel_quad_fetch #(
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 16,
  localparam int unsigned PIXEL_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [3:0]             conf_widthLog2,
  input  logic [3:0]             conf_heightLog2,
  input  logic                   conf_clampS,
  input  logic                   conf_clampT,
  output logic                   s_ready,
  input  logic                   s_valid,
  input  logic [USER_WIDTH-1:0]  s_user,
  input  logic [31:0]            s_texelS,
  input  logic [31:0]            s_texelT,
  output logic                   m_tex_rd,
  output logic [ADDR_WIDTH-1:0]  m_tex_addr,
  input  logic [PIXEL_WIDTH-1:0] m_tex_data,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [USER_WIDTH-1:0]  m_user,
  output logic [PIXEL_WIDTH-1:0] m_texel00,
  output logic [PIXEL_WIDTH-1:0] m_texel01,
  output logic [PIXEL_WIDTH-1:0] m_texel10,
  output logic [PIXEL_WIDTH-1:0] m_texel11,
  output logic [15:0]            m_texelSubCoordS,
  output logic [15:0]            m_texelSubCoordT
);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, WAIT, OUT} state_t;

  state_t                state, next_state;
  logic                  rd_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  accept_c;
  logic                  clamp_s_c, clamp_t_c;
  logic [31:0]           u_c, v_c;
  logic [15:0]           u0_c, u1_c, v0_c, v1_c;
  logic [ADDR_WIDTH-1:0] a00_c;
  logic [ADDR_WIDTH-1:0] a01_q, a10_q, a11_q;
  logic                  filt_q;

`ifdef TEXEL_QUAD_FETCH_CLAMP_EN
  assign clamp_s_c = conf_clampS;
  assign clamp_t_c = conf_clampT;
`else
  // Clamp tied off: the clamp compare logic folds away and repeat is always used.
  logic unused_clamp;
  assign unused_clamp = conf_clampS ^ conf_clampT;
  assign clamp_s_c    = 1'b0;
  assign clamp_t_c    = 1'b0;
`endif

  function automatic logic [15:0] wrap_coord(input logic [15:0] c, input logic [3:0] lg,
                                             input logic clamp);
    logic [15:0] last;
    last = 16'((17'(1) << lg) - 17'(1));
    if (clamp) begin
      if (c[15])    return 16'(0);
      if (c > last) return last;
      return c;
    end
    return c & last;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] texel_addr(input logic [15:0] u, input logic [15:0] v,
                                                       input logic [3:0] lg);
    return ADDR_WIDTH'(({16'h0, v} << lg) | {16'h0, u});
  endfunction

  // Sample-centre bias only applies when filtering.
  assign u_c  = (s_texelS << conf_widthLog2)  - (enable ? 32'h0000_8000 : 32'h0);
  assign v_c  = (s_texelT << conf_heightLog2) - (enable ? 32'h0000_8000 : 32'h0);
  assign u0_c = wrap_coord(u_c[31:16],          conf_widthLog2,  clamp_s_c);
  assign u1_c = wrap_coord(u_c[31:16] + 16'd1,  conf_widthLog2,  clamp_s_c);
  assign v0_c = wrap_coord(v_c[31:16],          conf_heightLog2, clamp_t_c);
  assign v1_c = wrap_coord(v_c[31:16] + 16'd1,  conf_heightLog2, clamp_t_c);
  assign a00_c = texel_addr(u0_c, v0_c, conf_widthLog2);

  assign s_ready  = (state == IDLE) || ((state == OUT) && m_ready);
  assign accept_c = s_valid && s_ready;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      m_tex_rd   <= 1'b0;
      m_tex_addr <= '0;
      m_valid    <= 1'b0;
    end else begin
      state      <= next_state;
      m_tex_rd   <= rd_d;
      m_tex_addr <= addr_d;
      m_valid    <= (next_state == OUT);
    end
  end

  always_comb begin
    next_state = state;
    rd_d       = 1'b0;
    addr_d     = m_tex_addr;
    case (state)
      IDLE:    if (s_valid) next_state = F0;
      F0:      next_state = filt_q ? F1 : WAIT;
      F1:      next_state = F2;
      F2:      next_state = F3;
      F3:      next_state = WAIT;
      WAIT:    next_state = OUT;
      OUT:     if (m_ready) next_state = s_valid ? F0 : IDLE;
      default: next_state = IDLE;
    endcase
    // Read strobe and address are registered against the state being entered.
    case (next_state)
      F0:      begin rd_d = 1'b1; addr_d = a00_c; end
      F1:      begin rd_d = 1'b1; addr_d = a01_q; end
      F2:      begin rd_d = 1'b1; addr_d = a10_q; end
      F3:      begin rd_d = 1'b1; addr_d = a11_q; end
      default: ;
    endcase
  end

  // Transaction latch at accept; each read's datum lands in the following state.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      filt_q           <= 1'b0;
      a01_q            <= '0;
      a10_q            <= '0;
      a11_q            <= '0;
      m_user           <= '0;
      m_texelSubCoordS <= '0;
      m_texelSubCoordT <= '0;
      m_texel00        <= '0;
      m_texel01        <= '0;
      m_texel10        <= '0;
      m_texel11        <= '0;
    end else begin
      if (accept_c) begin
        filt_q           <= enable;
        a01_q            <= texel_addr(u1_c, v0_c, conf_widthLog2);
        a10_q            <= texel_addr(u0_c, v1_c, conf_widthLog2);
        a11_q            <= texel_addr(u1_c, v1_c, conf_widthLog2);
        m_user           <= s_user;
        m_texelSubCoordS <= enable ? u_c[15:0] : 16'h0;
        m_texelSubCoordT <= enable ? v_c[15:0] : 16'h0;
      end
      case (state)
        F1: m_texel00 <= m_tex_data;
        F2: m_texel01 <= m_tex_data;
        F3: m_texel10 <= m_tex_data;
        WAIT: begin
          if (filt_q) begin
            m_texel11 <= m_tex_data;
          end else begin
            m_texel00 <= m_tex_data;
            m_texel01 <= m_tex_data;
            m_texel10 <= m_tex_data;
            m_texel11 <= m_tex_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_texel_quad_fetch.sv
// Bench for texel_quad_fetch: arithmetic reference model plus directed hand-computed vectors.
`timescale 1ns/1ps
module tb_texel_quad_fetch;

  localparam int unsigned UW = 4;
`ifdef TEXEL_QUAD_FETCH_CLAMP_EN
  localparam bit CLAMP_BUILT = 1'b1;
`else
  localparam bit CLAMP_BUILT = 1'b0;
`endif

  logic          aclk, resetn, enable, conf_clampS, conf_clampT;
  logic [3:0]    conf_widthLog2, conf_heightLog2;
  logic          s_ready, s_valid;
  logic [UW-1:0] s_user, m_user;
  logic [31:0]   s_texelS, s_texelT;
  logic          m_tex_rd, m_ready, m_valid;
  logic [15:0]   m_tex_addr, m_texelSubCoordS, m_texelSubCoordT;
  logic [31:0]   m_tex_data, m_texel00, m_texel01, m_texel10, m_texel11;

  texel_quad_fetch #(.USER_WIDTH(UW), .ADDR_WIDTH(16)) dut (
    .aclk(aclk), .resetn(resetn), .enable(enable),
    .conf_widthLog2(conf_widthLog2), .conf_heightLog2(conf_heightLog2),
    .conf_clampS(conf_clampS), .conf_clampT(conf_clampT),
    .s_ready(s_ready), .s_valid(s_valid), .s_user(s_user),
    .s_texelS(s_texelS), .s_texelT(s_texelT),
    .m_tex_rd(m_tex_rd), .m_tex_addr(m_tex_addr), .m_tex_data(m_tex_data),
    .m_ready(m_ready), .m_valid(m_valid), .m_user(m_user),
    .m_texel00(m_texel00), .m_texel01(m_texel01), .m_texel10(m_texel10), .m_texel11(m_texel11),
    .m_texelSubCoordS(m_texelSubCoordS), .m_texelSubCoordT(m_texelSubCoordT)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Texture memory: mem[a] = a, data one cycle after the strobe.
  always @(posedge aclk) m_tex_data <= m_tex_rd ? 32'(m_tex_addr) : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct {
    logic [31:0]   t00, t01, t10, t11;
    logic [15:0]   sub_s, sub_t;
    logic [UW-1:0] user;
  } exp_t;

  exp_t txq[$];
  int   rq[$];

  function automatic int wrap_ax(input int c, input int lg, input bit clamp);
    int sz;
    sz = 1 << lg;
    if (clamp) return (c < 0) ? 0 : ((c > sz - 1) ? sz - 1 : c);
    return ((c % sz) + sz) % sz;
  endfunction

  // Reference: texel coordinates by floor division and modulo/min-max, address = v*width + u.
  task automatic model_push(input logic [31:0] s, input logic [31:0] t, input bit en,
                            input logic [3:0] wl, input logic [3:0] hl, input bit cs, input bit ct,
                            input logic [UW-1:0] user);
    int u, v, bias, u0, u1, v0, v1, sw, a00, a01, a10, a11;
    exp_t e;
    bias = en ? 32'h8000 : 0;
    u  = int'(s << wl) - bias;
    v  = int'(t << hl) - bias;
    sw = 1 << int'(wl);
    u0 = wrap_ax(u >>> 16,       int'(wl), CLAMP_BUILT && cs);
    u1 = wrap_ax((u >>> 16) + 1, int'(wl), CLAMP_BUILT && cs);
    v0 = wrap_ax(v >>> 16,       int'(hl), CLAMP_BUILT && ct);
    v1 = wrap_ax((v >>> 16) + 1, int'(hl), CLAMP_BUILT && ct);
    a00 = (v0 * sw + u0) & 32'hFFFF;
    a01 = (v0 * sw + u1) & 32'hFFFF;
    a10 = (v1 * sw + u0) & 32'hFFFF;
    a11 = (v1 * sw + u1) & 32'hFFFF;
    e.user  = user;
    e.sub_s = en ? 16'(u & 32'hFFFF) : 16'h0;
    e.sub_t = en ? 16'(v & 32'hFFFF) : 16'h0;
    rq.push_back(a00);
    if (en) begin
      rq.push_back(a01); rq.push_back(a10); rq.push_back(a11);
      e.t00 = 32'(a00); e.t01 = 32'(a01); e.t10 = 32'(a10); e.t11 = 32'(a11);
    end else begin
      e.t00 = 32'(a00); e.t01 = 32'(a00); e.t10 = 32'(a00); e.t11 = 32'(a00);
    end
    txq.push_back(e);
  endtask

  // Per-cycle compare against the model.
  exp_t ce;
  always @(negedge aclk) begin
    if (!resetn) begin
      txq.delete();
      rq.delete();
    end else begin
      if (m_tex_rd) begin
        if (rq.size() == 0) fail_now("unexpected_read");
        else begin
          chk("read_addr", 32'(m_tex_addr), 32'(rq[0]));
          void'(rq.pop_front());
        end
      end
      if (m_valid) begin
        chk("no_read_in_out", 32'(m_tex_rd), 32'(0));
        chk("s_ready_in_out", 32'(s_ready), 32'(m_ready));
        if (txq.size() == 0) fail_now("unexpected_valid");
        else begin
          ce = txq[0];
          chk("m_texel00", m_texel00, ce.t00);
          chk("m_texel01", m_texel01, ce.t01);
          chk("m_texel10", m_texel10, ce.t10);
          chk("m_texel11", m_texel11, ce.t11);
          chk("m_sub_s", 32'(m_texelSubCoordS), 32'(ce.sub_s));
          chk("m_sub_t", 32'(m_texelSubCoordT), 32'(ce.sub_t));
          chk("m_user", 32'(m_user), 32'(ce.user));
          if (m_ready) void'(txq.pop_front());
        end
      end
      if (s_valid && s_ready)
        model_push(s_texelS, s_texelT, enable, conf_widthLog2, conf_heightLog2,
                   conf_clampS, conf_clampT, s_user);
    end
  end

  task automatic drive(input logic [31:0] s, input logic [31:0] t, input bit en,
                       input logic [3:0] wl, input logic [3:0] hl, input bit cs, input bit ct,
                       input logic [UW-1:0] user);
    s_texelS = s; s_texelT = t; enable = en;
    conf_widthLog2 = wl; conf_heightLog2 = hl;
    conf_clampS = cs; conf_clampT = ct; s_user = user;
    s_valid = 1'b1;
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (s_ready) begin acc = cyc; break; end
    end
    if (acc < 0) fail_now("accept_timeout");
    @(posedge aclk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int r);
    n = 0; r = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge aclk);
      if (m_tex_rd) r++;
      if (m_valid) begin n = i; return; end
    end
    fail_now("valid_timeout");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'(0));
    chk({tag, "_rd"},      32'(m_tex_rd), 32'(0));
    chk({tag, "_addr"},    32'(m_tex_addr), 32'(0));
    chk({tag, "_t00"},     m_texel00, 32'h0);
    chk({tag, "_t01"},     m_texel01, 32'h0);
    chk({tag, "_t10"},     m_texel10, 32'h0);
    chk({tag, "_t11"},     m_texel11, 32'h0);
    chk({tag, "_sub"},     {m_texelSubCoordS, m_texelSubCoordT}, 32'h0);
    chk({tag, "_user"},    32'(m_user), 32'(0));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(1));
  endtask

  // One 4x4 transaction with hand-computed quad, latency and read count.
  task automatic run_one(input string tag, input logic [31:0] s, input logic [31:0] t, input bit en,
                         input bit cs, input bit ct, input logic [UW-1:0] user,
                         input int lat, input int nrd,
                         input logic [31:0] e00, input logic [31:0] e01,
                         input logic [31:0] e10, input logic [31:0] e11,
                         input logic [15:0] es, input logic [15:0] et);
    int acc, n, r;
    drive(s, t, en, 4'd2, 4'd2, cs, ct, user);
    wait_accept(acc);
    wait_valid(n, r);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_reads"},   32'(r), 32'(nrd));
    chk({tag, "_t00"}, m_texel00, e00);
    chk({tag, "_t01"}, m_texel01, e01);
    chk({tag, "_t10"}, m_texel10, e10);
    chk({tag, "_t11"}, m_texel11, e11);
    chk({tag, "_sub"}, {m_texelSubCoordS, m_texelSubCoordT}, {es, et});
    chk({tag, "_user"}, 32'(m_user), 32'(user));
    @(posedge aclk); #1;
  endtask

  logic [31:0] vs [6];
  logic [31:0] vt [6];
  bit          ven[6];
  logic [3:0]  vwl[6];
  logic [3:0]  vhl[6];
  bit          vcs[6];
  bit          vct[6];
  int          acc_cyc[6];

  initial begin
    int acc, n, r;
    resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b1; enable = 1'b1;
    conf_widthLog2 = 4'd2; conf_heightLog2 = 4'd2; conf_clampS = 1'b0; conf_clampT = 1'b0;
    s_texelS = '0; s_texelT = '0; s_user = '0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_vals("rst_init");
    resetn = 1'b1;
    @(posedge aclk); #1;

    run_one("centre", 32'h8000, 32'h8000, 1'b1, 1'b0, 1'b0, 4'h3, 6, 4,
            32'd5, 32'd6, 32'd9, 32'd10, 16'h8000, 16'h8000);
    run_one("repeat", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h7, 6, 4,
            32'd15, 32'd12, 32'd3, 32'd0, 16'h8000, 16'h8000);
    if (CLAMP_BUILT)
      run_one("clamp", 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 4'h1, 6, 4,
              32'd0, 32'd0, 32'd0, 32'd0, 16'h8000, 16'h8000);
    else
      run_one("clamp_off", 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 4'h1, 6, 4,
              32'd15, 32'd12, 32'd3, 32'd0, 16'h8000, 16'h8000);
    run_one("nearest", 32'h8000, 32'h4000, 1'b0, 1'b0, 1'b0, 4'h5, 3, 1,
            32'd6, 32'd6, 32'd6, 32'd6, 16'h0, 16'h0);

    // Backpressure: A stalls in OUT while B waits on s_valid.
    m_ready = 1'b0;
    drive(32'h5000, 32'hC000, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 4'h9);
    wait_accept(acc);
    drive(32'h8000, 32'h4000, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 4'hA);
    wait_valid(n, r);
    chk("bp_latency", 32'(n), 32'(6));
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("bp_hold_valid", 32'(m_valid), 32'(1));
      chk("bp_hold_t00", m_texel00, 32'd8);
      chk("bp_hold_t01", m_texel01, 32'd9);
      chk("bp_hold_t10", m_texel10, 32'd12);
      chk("bp_hold_t11", m_texel11, 32'd13);
      chk("bp_hold_sub", {m_texelSubCoordS, m_texelSubCoordT}, 32'hC000_8000);
      chk("bp_no_rd", 32'(m_tex_rd), 32'(0));
      chk("bp_s_ready_low", 32'(s_ready), 32'(0));
    end
    @(posedge aclk); #1;
    m_ready = 1'b1;
    @(negedge aclk);
    chk("bp_accept_same_cycle", 32'(s_ready), 32'(1));
    @(posedge aclk); #1;
    s_valid = 1'b0;
    @(negedge aclk);
    chk("bp_b_read", 32'(m_tex_rd), 32'(1));
    chk("bp_b_addr", 32'(m_tex_addr), 32'd6);
    chk("bp_b_valid_low", 32'(m_valid), 32'(0));
    wait_valid(n, r);
    chk("bp_b_latency", 32'(n), 32'(2));
    chk("bp_b_t11", m_texel11, 32'd6);
    @(posedge aclk); #1;

    // Reset while the third read is on the bus.
    drive(32'h8000, 32'h8000, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 4'hC);
    wait_accept(acc);
    repeat (3) @(negedge aclk);
    chk("f2_rd", 32'(m_tex_rd), 32'(1));
    chk("f2_addr", 32'(m_tex_addr), 32'd9);
    #1 resetn = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge aclk);
    @(posedge aclk); #1;
    resetn = 1'b1;
    @(posedge aclk); #1;
    run_one("after_reset", 32'h8000, 32'h8000, 1'b1, 1'b0, 1'b0, 4'h6, 6, 4,
            32'd5, 32'd6, 32'd9, 32'd10, 16'h8000, 16'h8000);

    // Back-to-back mixed sizes, negative/large coordinates, model-checked.
    vs  = '{32'h0000_3000, 32'hFFFF_C000, 32'h0000_FFFF, 32'h1234_5678, 32'h0000_A000, 32'h0001_8000};
    vt  = '{32'h0000_F000, 32'h0001_8000, 32'h0000_0001, 32'h8765_4321, 32'h0000_2000, 32'hFFFE_0000};
    ven = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vwl = '{4'd3, 4'd8, 4'd0, 4'd5, 4'd4, 4'd2};
    vhl = '{4'd1, 4'd8, 4'd0, 4'd6, 4'd3, 4'd2};
    vcs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vct = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(vs[i], vt[i], ven[i], vwl[i], vhl[i], vcs[i], vct[i], UW'(i));
      wait_accept(acc_cyc[i]);
    end
    for (int i = 1; i < 6; i++)
      chk("throughput_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), ven[i-1] ? 32'd6 : 32'd3);

    for (int i = 0; i < 60 && txq.size() != 0; i++) @(negedge aclk);
    chk("drained_quads", 32'(txq.size()), 32'(0));
    chk("drained_reads", 32'(rq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

endmodule
